keylock_entry_sequencer: RTL

- Datapath and sequencing companion to the keylock controller FSM.
- Collects keypad digits into an entry buffer and compares it combinationally against the factory passcode, the staged candidate or the stored user code; this drives `match` and `ValidUC`.
- Stages and commits new user codes, and holds the lock indicator.
- Times the blink sequences that drive `DoneBlink` back to the controller.

---
 rtl/keylock_entry_sequencer.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/keylock_entry_sequencer.sv
// -----------------------------------------------------------------------------
// keylock_entry_sequencer
//
// Datapath and sequencing companion to the keylock controller FSM.
//   - Shifts keypad digits into an entry buffer (last DIGITS digits are kept).
//   - Compares the buffer against the factory passcode, the staged candidate
//     or the stored user code (combinational match / ValidUC).
//   - Stages and commits a new user code, holds the lock indicator LED1.
//   - Times the blink sequences and returns a one-cycle DoneBlink pulse.
//
// Optional feature (compile-time macro KEYLOCK_LOCKOUT_EN):
//   Defined   - three consecutive failures lock the keypad for LOCKOUT_CYCLES.
//   Undefined - lockout is tied low and no fail-counter logic exists.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   rdy          in   one-cycle keypress valid strobe
//   keypress     in   key code 0-15 (7/8/9 are command keys)
//   CheckPC      in   compare against PASSCODE
//   CheckValidUC in   entering a candidate user code
//   confirmUC    in   re-entering the candidate for confirmation
//   LOCKING      in   lock/unlock entry, compare against the user code
//   ToggleLED1   in   toggle lock indicator
//   error        in   failure blink request
//   Chillin      in   success blink request
//   match        out  combinational compare result
//   ValidUC      out  combinational candidate validity
//   DoneBlink    out  one-cycle pulse at the end of a blink sequence
//   LED1         out  lock indicator (1 = locked)
//   blink_led    out  blink drive
//   digit_count  out  digits held in the buffer
//   lockout      out  keypad locked out
// -----------------------------------------------------------------------------
module keylock_entry_sequencer #(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] PASSCODE       = 16'h1234,
    parameter int                  BLINK_HALF     = 12_500_000,
    parameter int                  BLINK_COUNT    = 3,
    parameter int                  LOCKOUT_CYCLES = 250_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rdy,
    input  logic [3:0]                   keypress,
    input  logic                         CheckPC,
    input  logic                         CheckValidUC,
    input  logic                         confirmUC,
    input  logic                         LOCKING,
    input  logic                         ToggleLED1,
    input  logic                         error,
    input  logic                         Chillin,
    output logic                         match,
    output logic                         ValidUC,
    output logic                         DoneBlink,
    output logic                         LED1,
    output logic                         blink_led,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         lockout
);

    localparam int W        = 4 * DIGITS;
    localparam int CNT_W    = $clog2(DIGITS + 1);
    localparam int HALF_W   = $clog2(BLINK_HALF + 1);
    localparam int HALVES_W = $clog2(2 * BLINK_COUNT + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(DIGITS);
    localparam logic [HALF_W-1:0]   HALF_LAST   = HALF_W'(BLINK_HALF - 1);
    localparam logic [HALVES_W-1:0] HALVES_LAST = HALVES_W'(2 * BLINK_COUNT - 1);

    logic [W-1:0]        entry_r, cand_r, uc_r, target_s;
    logic [CNT_W-1:0]    cnt_r;
    logic                uc_valid_r, led_r;
    logic                cmd_key_s, key8_s, rdy_ok_s, cmd_evt_s, digit_evt_s;
    logic                full_s, has_target_s, match_s, valid_uc_s, lockout_s;
    logic                req_s, req_q_r, start_s, running_r, blink_r, done_r;
    logic [HALF_W-1:0]   half_cnt_r, half_nxt_s;
    logic [HALVES_W-1:0] halves_r, halves_nxt_s;
    logic                done_nxt_s;

    assign cmd_key_s   = (keypress == 4'd7) || (keypress == 4'd8) || (keypress == 4'd9);
    assign key8_s      = (keypress == 4'd8);
    // A locked-out keypad sees no strobes at all: no capture and no clear.
    assign rdy_ok_s    = rdy & ~lockout_s;
    assign cmd_evt_s   = rdy_ok_s & cmd_key_s;
    assign digit_evt_s = rdy_ok_s & ~cmd_key_s & ~(error | Chillin);
    assign full_s      = (cnt_r == CNT_FULL);

    // Compare target selection, CheckPC has the highest priority.
    always_comb begin
        target_s     = {W{1'b0}};
        has_target_s = 1'b0;
        if (CheckPC) begin
            target_s     = PASSCODE;
            has_target_s = 1'b1;
        end else if (confirmUC) begin
            target_s     = cand_r;
            has_target_s = 1'b1;
        end else if (LOCKING) begin
            target_s     = uc_r;
            has_target_s = 1'b1;
        end else begin
            target_s     = {W{1'b0}};
            has_target_s = 1'b0;
        end
    end

    // An unprogrammed user code must never unlock, even if the buffer equals it.
    assign match_s    = full_s & has_target_s & (entry_r == target_s) & (LOCKING ? uc_valid_r : 1'b1);
    assign valid_uc_s = full_s & (entry_r != PASSCODE);
    assign match      = match_s;
    assign ValidUC    = valid_uc_s;

    // Entry buffer and digit counter; commands and end of blink clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_r <= {W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (cmd_evt_s || done_r) begin
            entry_r <= {W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (digit_evt_s) begin
            // Truncating the concatenation keeps only the newest DIGITS digits.
            entry_r <= W'({entry_r, keypress});
            cnt_r   <= full_s ? CNT_FULL : cnt_r + CNT_W'(1);
        end else begin
            entry_r <= entry_r;
            cnt_r   <= cnt_r;
        end
    end

    // Candidate staging and user-code commit on the key-8 strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_r     <= {W{1'b0}};
            uc_r       <= {W{1'b0}};
            uc_valid_r <= 1'b0;
        end else if (cmd_evt_s && key8_s && confirmUC && match_s) begin
            uc_r       <= cand_r;
            uc_valid_r <= 1'b1;
        end else if (cmd_evt_s && key8_s && CheckValidUC && valid_uc_s) begin
            cand_r     <= entry_r;
        end else begin
            cand_r     <= cand_r;
        end
    end

    // Lock indicator toggles once per ToggleLED1 cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_r <= 1'b0;
        end else if (ToggleLED1) begin
            led_r <= ~led_r;
        end else begin
            led_r <= led_r;
        end
    end

    assign req_s   = error | Chillin;
    assign start_s = req_s & ~req_q_r;

    // Next half-period position; DoneBlink is raised for the final cycle.
    always_comb begin
        half_nxt_s   = half_cnt_r + HALF_W'(1);
        halves_nxt_s = halves_r;
        if (half_cnt_r == HALF_LAST) begin
            half_nxt_s   = {HALF_W{1'b0}};
            halves_nxt_s = halves_r + HALVES_W'(1);
        end else begin
            half_nxt_s   = half_cnt_r + HALF_W'(1);
            halves_nxt_s = halves_r;
        end
        done_nxt_s = (halves_nxt_s == HALVES_LAST) && (half_nxt_s == HALF_LAST);
    end

    // Blink timer: starts on a request rising edge, runs to completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q_r    <= 1'b0;
            running_r  <= 1'b0;
            blink_r    <= 1'b0;
            done_r     <= 1'b0;
            half_cnt_r <= {HALF_W{1'b0}};
            halves_r   <= {HALVES_W{1'b0}};
        end else begin
            req_q_r <= req_s;
            if (running_r && done_r) begin
                running_r  <= 1'b0;
                blink_r    <= 1'b0;
                done_r     <= 1'b0;
                half_cnt_r <= {HALF_W{1'b0}};
                halves_r   <= {HALVES_W{1'b0}};
            end else if (running_r) begin
                half_cnt_r <= half_nxt_s;
                halves_r   <= halves_nxt_s;
                blink_r    <= (half_cnt_r == HALF_LAST) ? ~blink_r : blink_r;
                done_r     <= done_nxt_s;
            end else if (start_s) begin
                running_r  <= 1'b1;
                blink_r    <= 1'b1;
                done_r     <= 1'b0;
                half_cnt_r <= {HALF_W{1'b0}};
                halves_r   <= {HALVES_W{1'b0}};
            end else begin
                blink_r    <= 1'b0;
                done_r     <= 1'b0;
            end
        end
    end

    assign DoneBlink   = done_r;
    assign blink_led   = blink_r;
    assign LED1        = led_r;
    assign digit_count = cnt_r;

`ifdef KEYLOCK_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic              err_q_r, chl_q_r, lockout_r;
    logic [1:0]        fail_cnt_r;
    logic [LOCK_W-1:0] lock_cnt_r;

    // Consecutive-failure counter and lockout timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q_r    <= 1'b0;
            chl_q_r    <= 1'b0;
            lockout_r  <= 1'b0;
            fail_cnt_r <= 2'd0;
            lock_cnt_r <= {LOCK_W{1'b0}};
        end else begin
            err_q_r <= error;
            chl_q_r <= Chillin;
            if (lockout_r) begin
                if (lock_cnt_r == {LOCK_W{1'b0}}) begin
                    lockout_r  <= 1'b0;
                    fail_cnt_r <= 2'd0;
                end else begin
                    lock_cnt_r <= lock_cnt_r - LOCK_W'(1);
                end
            end else if (done_r && (fail_cnt_r == 2'd3)) begin
                lockout_r  <= 1'b1;
                lock_cnt_r <= LOCK_LAST;
            end else if ((Chillin && !chl_q_r) || ToggleLED1) begin
                fail_cnt_r <= 2'd0;
            end else if (error && !err_q_r && (fail_cnt_r != 2'd3)) begin
                fail_cnt_r <= fail_cnt_r + 2'd1;
            end else begin
                fail_cnt_r <= fail_cnt_r;
            end
        end
    end

    assign lockout_s = lockout_r;
    assign lockout   = lockout_r;
`else
    assign lockout_s = 1'b0;
    // Always low; the term only keeps LOCKOUT_CYCLES referenced in this build.
    assign lockout   = 1'b0 & (LOCKOUT_CYCLES > 0);
`endif

endmodule
